// File: rtl/mini_arith_sequencer.sv
// Clocked valid/ready front-end for the mini arithmetic core (A-1, A+B, A-B, -B).
// Drives the core pins, samples G/carry after a settle delay and checks them.
module mini_arith_sequencer #(
  parameter int unsigned W      = 3,
  parameter int unsigned SETTLE = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  output logic             core_s1,
  output logic             core_s0,
  output logic [W-1:0]     core_a,
  output logic [W-1:0]     core_b,
  input  logic [W-1:0]     core_g,
  input  logic             core_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_g,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic             busy
);

  localparam int unsigned CntW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [W-1:0] MinNeg = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StDrive, StResp} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_g_q, rsp_g_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_mm_q, rsp_mm_d;
  logic [CNT_W-1:0] err_q, err_d;

  // Expected result as a single W+1 bit add: x + y + cin, carry in bit W.
  logic [W-1:0] add_x, add_y;
  logic         add_cin;
  logic [W:0]   exp_sum;
  logic         exp_ovf;
  logic         exp_mm;

  always_comb begin
    add_x   = a_q;
    add_y   = b_q;
    add_cin = 1'b0;
    unique case (op_q)
      2'b00: begin
        add_x   = a_q;
        add_y   = '1;
        add_cin = 1'b0;
      end
      2'b01: begin
        add_x   = a_q;
        add_y   = b_q;
        add_cin = 1'b0;
      end
      2'b10: begin
        add_x   = a_q;
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      2'b11: begin
        add_x   = '0;
        add_y   = ~b_q;
        add_cin = 1'b1;
      end
      default: ;
    endcase
    exp_sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_cin};
  end

  always_comb begin
    exp_ovf = 1'b0;
    unique case (op_q)
      2'b00: exp_ovf = (a_q == MinNeg);
      2'b01: exp_ovf = (a_q[W-1] == b_q[W-1]) && (exp_sum[W-1] != a_q[W-1]);
      2'b10: exp_ovf = (a_q[W-1] != b_q[W-1]) && (exp_sum[W-1] != a_q[W-1]);
      2'b11: exp_ovf = (b_q == MinNeg);
      default: ;
    endcase
    exp_mm = {core_g, core_carry} != {exp_sum[W-1:0], exp_sum[W]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_g_d     = rsp_g_q;
    rsp_carry_d = rsp_carry_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_mm_d    = rsp_mm_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          a_d     = cmd_a;
          b_d     = cmd_b;
          cnt_d   = CntW'(SETTLE - 1);
          state_d = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CntW'(1);
        end else begin
          rsp_g_d     = core_g;
          rsp_carry_d = core_carry;
          rsp_ovf_d   = exp_ovf;
          rsp_mm_d    = exp_mm;
          rsp_valid_d = 1'b1;
          if (exp_mm && (err_q != '1)) begin
            err_d = err_q + CNT_W'(1);
          end
          state_d = StResp;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      rsp_valid_q <= 1'b0;
      rsp_g_q     <= '0;
      rsp_carry_q <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_mm_q    <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_g_q     <= rsp_g_d;
      rsp_carry_q <= rsp_carry_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_mm_q    <= rsp_mm_d;
      err_q       <= err_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign busy         = (state_q != StIdle);
  assign core_s1      = op_q[1];
  assign core_s0      = op_q[0];
  assign core_a       = a_q;
  assign core_b       = b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_g        = rsp_g_q;
  assign rsp_carry    = rsp_carry_q;
  assign rsp_ovf      = rsp_ovf_q;
  assign rsp_mismatch = rsp_mm_q;
  assign err_count    = err_q;

  // A stalled response must not move, and the core sees steady pins while busy.
  rsp_stable_a: assert property (@(posedge clk) disable iff (rst)
    rsp_valid && !rsp_ready |=> rsp_valid &&
      $stable({rsp_g, rsp_carry, rsp_ovf, rsp_mismatch}));

  pins_held_a: assert property (@(posedge clk) disable iff (rst)
    !cmd_ready |=> $stable({core_s1, core_s0, core_a, core_b}));

endmodule

// File: tb/tb_mini_arith_sequencer.sv
// Randomised bench for mini_arith_sequencer with an integer-arithmetic reference model
// and a behavioural core that can inject a stuck G bit or an inverted carry.
module tb_mini_arith_sequencer;

  localparam int unsigned W      = 3;
  localparam int unsigned SETTLE = 2;
  localparam int unsigned CNT_W  = 8;
  localparam int          ErrMax = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic             core_s1;
  logic             core_s0;
  logic [W-1:0]     core_a;
  logic [W-1:0]     core_b;
  logic [W-1:0]     core_g;
  logic             core_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_g;
  logic             rsp_carry;
  logic             rsp_ovf;
  logic             rsp_mismatch;
  logic [CNT_W-1:0] err_count;
  logic             busy;

  mini_arith_sequencer #(
    .W      (W),
    .SETTLE (SETTLE),
    .CNT_W  (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .core_s1      (core_s1),
    .core_s0      (core_s0),
    .core_a       (core_a),
    .core_b       (core_b),
    .core_g       (core_g),
    .core_carry   (core_carry),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_g        (rsp_g),
    .rsp_carry    (rsp_carry),
    .rsp_ovf      (rsp_ovf),
    .rsp_mismatch (rsp_mismatch),
    .err_count    (err_count),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Ideal core: {carry, G} from unsigned arithmetic on 3-bit values.
  function automatic logic [3:0] ideal(input logic [1:0] op, input logic [2:0] a,
                                       input logic [2:0] b);
    int u;
    case (op)
      2'b00:   u = int'(a) + 7;
      2'b01:   u = int'(a) + int'(b);
      2'b10:   u = int'(a) + 8 - int'(b);
      default: u = 8 - int'(b);
    endcase
    return 4'(u);
  endfunction

  // Signed overflow: true signed result falls outside [-4, 3].
  function automatic logic ovf_of(input logic [1:0] op, input logic [2:0] a,
                                  input logic [2:0] b);
    int sa;
    int sb;
    int t;
    sa = (a >= 3'd4) ? int'(a) - 8 : int'(a);
    sb = (b >= 3'd4) ? int'(b) - 8 : int'(b);
    case (op)
      2'b00:   t = sa - 1;
      2'b01:   t = sa + sb;
      2'b10:   t = sa - sb;
      default: t = -sb;
    endcase
    return (t < -4) || (t > 3);
  endfunction

  // Fault configuration is latched at command accept so it stays fixed per transaction.
  logic       f_stuck, f_flip;
  logic       lat_stuck, lat_flip;
  logic [3:0] core_ideal;
  assign core_ideal = ideal({core_s1, core_s0}, core_a, core_b);
  assign core_g     = lat_stuck ? (core_ideal[2:0] & 3'b110) : core_ideal[2:0];
  assign core_carry = core_ideal[3] ^ lat_flip;

  typedef struct {
    int         acc;
    logic [2:0] g;
    logic       c;
    logic       o;
    logic       m;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  bit         mvalid = 0;
  logic [1:0] m_op;
  logic [2:0] m_a, m_b, m_rg;
  logic       m_rv, m_rc, m_ro, m_rm;
  int         m_err;
  int         rdy_mode;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_op  = '0;
    m_a   = '0;
    m_b   = '0;
    m_rv  = 1'b0;
    m_rg  = '0;
    m_rc  = 1'b0;
    m_ro  = 1'b0;
    m_rm  = 1'b0;
    m_err = 0;
  endtask

  // Compare every output to the model, then advance the model for the coming edge.
  task automatic monitor();
    exp_t e;
    logic [3:0] r;
    cyc++;
    if (mvalid) begin
      if ((q.size() > 0) && !m_rv && (cyc == q[0].acc + int'(SETTLE) + 1)) begin
        m_rv = 1'b1;
        m_rg = q[0].g;
        m_rc = q[0].c;
        m_ro = q[0].o;
        m_rm = q[0].m;
        if (q[0].m && (m_err < ErrMax)) m_err++;
      end
      chk("cmd_ready", int'(cmd_ready), int'(q.size() == 0));
      chk("busy", int'(busy), int'(q.size() != 0));
      chk("rsp_valid", int'(rsp_valid), int'(m_rv));
      chk("rsp_g", int'(rsp_g), int'(m_rg));
      chk("rsp_carry", int'(rsp_carry), int'(m_rc));
      chk("rsp_ovf", int'(rsp_ovf), int'(m_ro));
      chk("rsp_mismatch", int'(rsp_mismatch), int'(m_rm));
      chk("err_count", int'(err_count), m_err);
      chk("core_op", int'({core_s1, core_s0}), int'(m_op));
      chk("core_a", int'(core_a), int'(m_a));
      chk("core_b", int'(core_b), int'(m_b));
    end
    if (rst) begin
      model_reset();
      mvalid = 1'b1;
    end else if (mvalid) begin
      if (m_rv && rsp_ready) begin
        void'(q.pop_front());
        m_rv = 1'b0;
      end else if ((q.size() == 0) && cmd_valid) begin
        r     = ideal(cmd_op, cmd_a, cmd_b);
        e.acc = cyc;
        e.g   = f_stuck ? (r[2:0] & 3'b110) : r[2:0];
        e.c   = r[3] ^ f_flip;
        e.o   = ovf_of(cmd_op, cmd_a, cmd_b);
        e.m   = (e.g != r[2:0]) || (e.c != r[3]);
        q.push_back(e);
        m_op      = cmd_op;
        m_a       = cmd_a;
        m_b       = cmd_b;
        lat_stuck = f_stuck;
        lat_flip  = f_flip;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rdy_mode == 0) rsp_ready = 1'($urandom_range(1, 0));
    else if (rdy_mode == 1) rsp_ready = 1'b1;
  endtask

  task automatic send(input logic [1:0] op, input logic [2:0] a, input logic [2:0] b);
    int  n;
    bit  acc;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    n   = 0;
    acc = 1'b0;
    while (!acc && (n < 50)) begin
      acc = cmd_ready;
      tick();
      n++;
    end
    cmd_valid = 1'b0;
    chk("send_accept", int'(acc), 1);
  endtask

  // Returns edges after the accept edge; the handshake cycle itself adds one more.
  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && (n < 20)) begin
      tick();
      n++;
    end
    chk("latency", n + 1, int'(SETTLE) + 1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (busy && (n < 100)) begin
      tick();
      n++;
    end
    chk("drain_idle", int'(busy), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish by 1ms");
    $fatal(1);
  end

  initial begin
    lat_stuck = 1'b0;
    lat_flip  = 1'b0;
    f_stuck   = 1'b0;
    f_flip    = 1'b0;
    rdy_mode  = 2;
    rsp_ready = 1'b0;
    model_reset();

    // Reset with a command held valid: nothing may be accepted.
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_a     = 3'd3;
    cmd_b     = 3'd1;
    repeat (3) tick();
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    rst       = 1'b0;
    cmd_valid = 1'b0;
    tick();
    chk("post_rst_cmd_ready", int'(cmd_ready), 1);
    chk("post_rst_rsp_valid", int'(rsp_valid), 0);
    chk("post_rst_core_a", int'(core_a), 0);
    chk("post_rst_core_b", int'(core_b), 0);
    chk("post_rst_err", int'(err_count), 0);

    send(2'b00, 3'b000, 3'b000);
    wait_rsp();
    chk("dec_g", int'(rsp_g), 7);
    chk("dec_carry", int'(rsp_carry), 0);
    chk("dec_ovf", int'(rsp_ovf), 0);
    chk("dec_mm", int'(rsp_mismatch), 0);
    consume();

    send(2'b10, 3'b000, 3'b000);
    wait_rsp();
    chk("sub_g", int'(rsp_g), 0);
    chk("sub_carry", int'(rsp_carry), 1);
    consume();

    send(2'b01, 3'b011, 3'b010);
    wait_rsp();
    chk("add_g", int'(rsp_g), 5);
    chk("add_carry", int'(rsp_carry), 0);
    chk("add_ovf", int'(rsp_ovf), 1);
    consume();

    send(2'b11, 3'b000, 3'b100);
    wait_rsp();
    chk("neg_g", int'(rsp_g), 4);
    chk("neg_carry", int'(rsp_carry), 0);
    chk("neg_ovf", int'(rsp_ovf), 1);
    cmd_op    = 2'b00;
    cmd_a     = 3'd1;
    cmd_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall_valid", int'(rsp_valid), 1);
      chk("stall_g", int'(rsp_g), 4);
      chk("stall_ovf", int'(rsp_ovf), 1);
      chk("stall_cmd_ready", int'(cmd_ready), 0);
    end
    cmd_valid = 1'b0;
    consume();

    // G bit 0 stuck low: A+B = 1 comes back as 0.
    f_stuck = 1'b1;
    send(2'b01, 3'b000, 3'b001);
    wait_rsp();
    chk("stuck_mm", int'(rsp_mismatch), 1);
    chk("stuck_g", int'(rsp_g), 0);
    chk("stuck_err", int'(err_count), 1);
    consume();
    rdy_mode = 1;
    for (int i = 0; i < 299; i++) send(2'b01, 3'b000, 3'b001);
    drain();
    chk("err_saturated", int'(err_count), 255);
    f_stuck  = 1'b0;
    rdy_mode = 2;
    rsp_ready = 1'b0;

    // Reset while in DRIVE aborts the command and clears the counter.
    send(2'b01, 3'b001, 3'b001);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_rsp_valid", int'(rsp_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_err", int'(err_count), 0);
    send(2'b10, 3'b011, 3'b001);
    wait_rsp();
    chk("after_abort_g", int'(rsp_g), 2);
    chk("after_abort_carry", int'(rsp_carry), 1);
    chk("after_abort_mm", int'(rsp_mismatch), 0);
    consume();

    rdy_mode = 0;
    for (int i = 0; i < 400; i++) begin
      f_stuck = ($urandom_range(9, 0) == 0);
      f_flip  = ($urandom_range(9, 0) == 0);
      send(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
      repeat ($urandom_range(2, 0)) tick();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
